// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes and the multiply sequencer state encoding.
package cpu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_XOR = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_ADD = 3'b011;
    localparam logic [2:0] ALU_CMP = 3'b100;
    localparam logic [2:0] ALU_ORR = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/mul_datapath.sv
// Radix-2 shift-add datapath: accumulator, shifting multiplicand and multiplier.
// i_load captures fresh operands and clears the accumulator; i_step performs one iteration.
module mul_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic [WIDTH-1:0] o_acc_next
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;

    // Accumulator value after the current iteration; the sum wraps to WIDTH bits.
    assign o_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Operand/accumulator registers: load takes priority, step shifts one bit position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= i_op_a;
            r_mplier <= i_op_b;
        end else if (i_step) begin
            r_acc    <= o_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Iterative multiply controller for the execute stage. Owns the IDLE/BUSY/DONE FSM,
// the iteration counter, the registered result/flags and the pipeline stall request.
// Handshake: a MUL is accepted on any edge where start=1, flush=0 and the FSM is in
// IDLE or DONE; stall_e holds the instruction in execute until done pulses.
module mul_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall_e,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic [1:0]       o_dbg_state
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    mul_state_t       r_state;
    mul_state_t       w_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_flag_n;
    logic             r_flag_z;
    logic             w_accept;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;

    assign w_accept = start & ~flush;
    assign w_last   = (r_count == LAST);

    mul_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_op_a     (op_a),
        .i_op_b     (op_b),
        .o_acc_next (w_acc_next)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and datapath strobes; flush always wins and returns to IDLE.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    w_next = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    w_next = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_last) w_next = DONE;
                end
            end
            DONE: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    w_next = BUSY;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Iteration counter: cleared on load, advanced once per BUSY step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_count <= '0;
        else if (w_load) r_count <= '0;
        else if (w_step) r_count <= r_count + 1'b1;
    end

    // Result and flags capture the final accumulator and hold until the next product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b0;
        end else if (w_step && w_last) begin
            r_result <= w_acc_next;
            r_flag_n <= w_acc_next[WIDTH-1];
            r_flag_z <= (w_acc_next == '0);
        end
    end

    // Stall is combinational so a newly arriving MUL is frozen in its first cycle.
    assign stall_e     = ((r_state == IDLE) & w_accept) | (r_state == BUSY);
    assign busy        = (r_state == BUSY);
    assign done        = (r_state == DONE);
    assign result      = r_result;
    assign flag_n      = r_flag_n;
    assign flag_z      = r_flag_z;
    assign o_dbg_state = r_state;

endmodule
